// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends data[len-1:0] MSB first, rep+1 times,
// with a one-cycle zero gap between passes. Define SEQ_TX_PARITY_EN to append an odd-parity bit per pass.
module seq_tx #(
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DW-1:0]         data,
    input  logic [$clog2(DW):0]   len,
    input  logic [3:0]            rep,
    output logic                  ready,
    output logic                  out,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = $clog2(DW) + 1;
    localparam logic [LW-1:0] DW_L = LW'(DW);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3
`ifdef SEQ_TX_PARITY_EN
        , PAR = 3'd4
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [LW-1:0]   len_q, len_d;
    logic [3:0]      rep_q, rep_d;
    logic [LW-1:0]   bit_q, bit_d;
    logic [3:0]      pass_q, pass_d;
    logic            out_d, done_d, busy_d;
    logic [LW-1:0]   len_eff;
    logic            last_pass;

    function automatic logic bit_at(input logic [DW-1:0] d, input logic [LW-1:0] idx);
        logic [DW-1:0] s;
        s = d >> idx;
        return s[0];
    endfunction

    // Zero and out-of-range lengths both select the full word width.
    assign len_eff   = (len == '0 || len > DW_L) ? DW_L : len;
    assign last_pass = (pass_q == rep_q);
    assign ready     = (state_q == IDLE);

`ifdef SEQ_TX_PARITY_EN
    logic [DW-1:0] field_mask;
    logic          parity;
    assign field_mask = {DW{1'b1}} >> (DW_L - len_q);
    assign parity     = ~^(data_q & field_mask);
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves a latch.
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        rep_d   = rep_q;
        bit_d   = bit_q;
        pass_d  = pass_q;
        out_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data;
                    len_d   = len_eff;
                    rep_d   = rep;
                    bit_d   = len_eff - 1'b1;
                    pass_d  = '0;
                    out_d   = bit_at(data, len_eff - 1'b1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                    out_d = bit_at(data_q, bit_q - 1'b1);
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    out_d   = parity;
                    state_d = PAR;
`else
                    state_d = last_pass ? DONE : GAP;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: state_d = last_pass ? DONE : GAP;
`endif
            GAP: begin
                pass_d  = pass_q + 1'b1;
                bit_d   = len_q - 1'b1;
                out_d   = bit_at(data_q, len_q - 1'b1);
                state_d = SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            pass_q  <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            pass_q  <= pass_d;
            out     <= out_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: streams, gaps, done pulse, busy length, dropped start and async reset.
module tb_seq_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] rep;
    logic       ready, out, busy, done;

    int checks = 0;
    int errors = 0;

    seq_tx #(.DW(8)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .data  (data),
        .len   (len),
        .rep   (rep),
        .ready (ready),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge while idle; exp holds the expected out stream, first bit at exp[n-1].
    task automatic run_xfer(input string tag, input logic [7:0] d, input logic [3:0] l,
                            input logic [3:0] r, input logic [63:0] exp, input int n);
        int busy_cnt;
        busy_cnt = 0;
        start = 1'b1; data = d; len = l; rep = r;
        check({tag, " ready_before"}, ready, 1);
        @(negedge clk);
        // Scramble inputs: the transfer must run from its captured copies.
        start = 1'b0; data = ~d; len = 4'd1; rep = 4'd15;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s out[%0d]", tag, i), out, exp[n-1-i]);
            check($sformatf("%s done_low[%0d]", tag, i), done, 0);
            busy_cnt += int'(busy);
            @(negedge clk);
        end
        check({tag, " done_pulse"}, done, 1);
        check({tag, " out_in_done"}, out, 0);
        busy_cnt += int'(busy);
        @(negedge clk);
        check({tag, " ready_after"}, ready, 1);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " done_after"}, done, 0);
        check({tag, " busy_cycles"}, busy_cnt, n + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; data = '0; len = '0; rep = '0;
        #12;
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        check("reset out", out, 0);
        check("reset done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

`ifdef SEQ_TX_PARITY_EN
        run_xfer("par_03", 8'h03, 4'd8, 4'd0, 64'b0000_0011_1, 9);
`else
        run_xfer("b3", 8'hB3, 4'd8, 4'd0, 64'b1011_0011, 8);
        run_xfer("06x3", 8'h06, 4'd3, 4'd2, 64'b110_0_110_0_110, 11);
        run_xfer("len0", 8'h81, 4'd0, 4'd0, 64'b1000_0001, 8);
        run_xfer("rep15", 8'h01, 4'd1, 4'd15, 64'h5555_5555, 31);
`endif

        // A start arriving mid-transfer is dropped and leaves the captured word intact.
        start = 1'b1; data = 8'h00; len = 4'd8; rep = 4'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drop out[%0d]", i), out, 0);
            if (i == 2) begin
                check("drop ready_low", ready, 0);
                start = 1'b1; data = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
`ifdef SEQ_TX_PARITY_EN
        check("drop parity", out, 1);
        @(negedge clk);
`endif
        check("drop done", done, 1);
        @(negedge clk);
        check("drop idle_busy", busy, 0);
        @(negedge clk);
        check("drop no_second", busy, 0);
        check("drop no_second_out", out, 0);

        // Asynchronous reset during the 5th bit of an all-ones word.
        start = 1'b1; data = 8'hFF; len = 4'd8; rep = 4'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("rst 5th_bit", out, 1);
        check("rst busy_before", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst out", out, 0);
        check("rst busy", busy, 0);
        check("rst ready", ready, 1);
        check("rst done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst no_done[%0d]", i), done, 0);
            check($sformatf("rst idle[%0d]", i), busy, 0);
        end

`ifdef SEQ_TX_PARITY_EN
        run_xfer("post_rst", 8'hA5, 4'd4, 4'd0, 64'b0101_1, 5);
`else
        run_xfer("post_rst", 8'hA5, 4'd4, 4'd0, 64'b0101, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 SHALL have parameter DW, default 8, maximum serial word width in bits (range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to transmit; sampled on the rising edge of clk.
REQ-005 SHALL have port data  input  DW  pattern to send; the active field is data[len-1:0], sent MSB first.
REQ-006 SHALL have port len  input  clog2(DW)+1  active field length; 0 means DW.
REQ-007 SHALL have port rep  input  4  extra passes; total passes = rep+1.
REQ-008 SHALL have port ready  output  1  high only in IDLE; start is accepted when start and ready are both high.
REQ-009 SHALL have port out  output  1  registered serial bit stream; drives a consecutive-ones detector input.
REQ-010 SHALL have port busy  output  1  registered; high in SHIFT, PAR, GAP and DONE.
REQ-011 SHALL have port done  output  1  registered one-cycle pulse marking the end of the transfer.

Function
REQ-012 SHALL implement the states IDLE, SHIFT, PAR, GAP and DONE in a registered state variable.
REQ-013 SHALL, on the accepting edge, capture data, len (0 mapped to DW) and rep, load out with data[len-1], and enter SHIFT.
REQ-014 SHALL, in SHIFT, present the next lower bit on out at each edge, so a pass of len bits occupies exactly len consecutive cycles.
REQ-015 SHALL, after the last bit of a pass, go to PAR if parity is compiled in (REQ-023), and otherwise to GAP if passes remain or to DONE if none remain.
REQ-016 SHALL, in GAP, drive out=0 for exactly one cycle, then reload data[len-1] and return to SHIFT.
REQ-017 SHALL, in DONE, drive out=0 and done=1 for exactly one cycle, then enter IDLE with busy=0 and ready=1.
REQ-018 SHALL, in IDLE, hold out=0 and done=0.
REQ-019 SHALL ignore start while busy, without corrupting the captured fields.
REQ-020 SHALL use only the captured copies during a transfer; changes on data, len or rep mid-transfer have no effect.
REQ-021 SHALL use 4-bit pass and clog2(DW)+1-bit bit counters; rep=15 yields 16 passes with no wrap.

Reset
REQ-022 SHALL, while rstn=0 (including mid-transfer), immediately force state=IDLE, out=0, busy=0, done=0, ready=1 and clear the counters and captured fields; normal operation resumes at the first clk edge after rstn rises.

Configuration
REQ-023 SHALL, with macro SEQ_TX_PARITY_EN defined, insert the PAR state after each pass; PAR drives out = ~^(active field) (odd parity) for one cycle, then goes to GAP or DONE.
REQ-024 SHALL, without SEQ_TX_PARITY_EN, contain no PAR state or logic; SHIFT goes directly to GAP or DONE.

Verification
REQ-025 SHALL cover: data=8'hB3, len=8, rep=0 -> out=1,0,1,1,0,0,1,1 in the 8 cycles after accept, then done=1 for one cycle with out=0, then ready=1.
REQ-026 SHALL cover: data=8'h06, len=3, rep=2 -> out=1,1,0,0,1,1,0,0,1,1,0, then a done pulse; busy is high for 12 cycles.
REQ-027 SHALL cover: len=0, data=8'h81 -> 8 bits 1,0,0,0,0,0,0,1 are sent.
REQ-028 SHALL cover: start pulsed with data=8'hFF during the 3rd bit of an 8'h00 transfer -> the stream remains all zeros and the second request is dropped.
REQ-029 SHALL cover: rstn driven low during the 5th bit, asynchronously to clk -> out=0, busy=0 and ready=1 before the next edge, and no done pulse.
REQ-030 SHALL cover, with SEQ_TX_PARITY_EN: data=8'h03, len=8, rep=0 -> 8 data bits, then a parity bit of 1, then done.
